// File: rtl/mode_sequencer.sv
// Debounced mode controller: synchronized advance/clear keys drive a wrapping MODE index with change strobe and blanking.
// Optional MODE_AUTO_CYCLE_EN adds a periodic auto-advance while the key FSM is idle and AUTO_EN is high.
//
// state      | meaning
// IDLE       | key released and stable, waiting for a press
// PRESS_WAIT | key low, counting stable cycles before accepting
// HELD       | press accepted, waiting for release (no repeat)
// REL_WAIT   | key high, counting stable cycles before re-arming
module mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = 2,
  parameter int BLANK_CYCLES    = 2500000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  input  logic              KEY_ADV_N,
  input  logic              KEY_CLR_N,
  input  logic              AUTO_EN,
  output logic [MODE_W-1:0] MODE,
  output logic              MODE_STROBE,
  output logic              BLANK
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLK_LOAD  = BLK_W'(BLANK_CYCLES);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [BLK_W-1:0]  blank_q, blank_d;
  logic              strobe_q;
  logic              adv_meta_q, adv_s_q, clr_meta_q, clr_s_q;
  logic              manual_action, auto_action, action;

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      adv_meta_q <= 1'b1;
      adv_s_q    <= 1'b1;
      clr_meta_q <= 1'b1;
      clr_s_q    <= 1'b1;
    end else begin
      adv_meta_q <= KEY_ADV_N;
      adv_s_q    <= adv_meta_q;
      clr_meta_q <= KEY_CLR_N;
      clr_s_q    <= clr_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    manual_action = 1'b0;
    case (state_q)
      IDLE: begin
        if (!adv_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (adv_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = HELD;
          manual_action = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (adv_s_q) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (!adv_s_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = REL_WAIT;
    endcase
  end

`ifdef MODE_AUTO_CYCLE_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

  // A press leaving IDLE on the terminal cycle clears the counter and wins.
  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_action = 1'b0;
    if (state_q != IDLE || state_d != IDLE || !AUTO_EN || manual_action) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == AUTO_LAST) begin
      auto_action = 1'b1;
      auto_cnt_d  = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) auto_cnt_q <= '0;
    else          auto_cnt_q <= auto_cnt_d;
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = AUTO_EN;
  assign auto_action    = 1'b0;
`endif

  assign action = manual_action | auto_action;

  always_comb begin
    mode_d  = mode_q;
    blank_d = blank_q;
    if (action) begin
      if (manual_action && !clr_s_q) mode_d = '0;
      else mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
      blank_d = BLK_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - BLK_W'(1);
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= REL_WAIT;
      cnt_q    <= '0;
      mode_q   <= '0;
      blank_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      blank_q  <= blank_d;
      strobe_q <= action;
    end
  end

  assign MODE        = mode_q;
  assign MODE_STROBE = strobe_q;
  assign BLANK       = (blank_q != '0);

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with short debounce/blank/auto periods.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_adv_n, key_clr_n, auto_en;
  logic [1:0] mode;
  logic       mode_strobe, blank;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int snap;
  int exp_mode = 0;

  always #5 clk = ~clk;

  mode_sequencer #(
    .DEBOUNCE_CYCLES(4), .NUM_MODES(4), .MODE_W(2), .BLANK_CYCLES(3), .AUTO_PERIOD(10)
  ) dut (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .KEY_ADV_N(key_adv_n), .KEY_CLR_N(key_clr_n),
    .AUTO_EN(auto_en), .MODE(mode), .MODE_STROBE(mode_strobe), .BLANK(blank)
  );

  always @(posedge clk) begin
    #1;
    if (mode_strobe === 1'b1) strobe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int lo, input int hi);
    key_adv_n = 1'b0;
    cyc(lo);
    key_adv_n = 1'b1;
    cyc(hi);
  endtask

  initial begin
    int strobe_at[$];
    rst_n = 1'b0; key_adv_n = 1'b1; key_clr_n = 1'b1; auto_en = 1'b0;
    cyc(3);
    chk("reset_mode", 32'(mode), 0);
    chk("reset_strobe", 32'(mode_strobe), 0);
    chk("reset_blank", 32'(blank), 0);
    rst_n = 1'b1;
    cyc(8);

    // 1: fall sampled by sync at edge 1, FSM reaches action on edge 7
    key_adv_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk($sformatf("t1_mode_%0d", i), 32'(mode), (i >= 7) ? 1 : 0);
      chk($sformatf("t1_strobe_%0d", i), 32'(mode_strobe), (i == 7) ? 1 : 0);
      chk($sformatf("t1_blank_%0d", i), 32'(blank), (i >= 7 && i <= 9) ? 1 : 0);
    end
    key_adv_n = 1'b1;
    cyc(12);
    exp_mode = 1;

    // 2: four clean presses, one strobe each
    for (int p = 0; p < 4; p++) begin
      snap = strobe_cnt;
      press(12, 12);
      exp_mode = (exp_mode + 1) % 4;
      chk($sformatf("t2_mode_%0d", p), 32'(mode), 32'(exp_mode));
      chk($sformatf("t2_strobes_%0d", p), 32'(strobe_cnt - snap), 1);
    end

    // 3: short glitch rejected, release bounce absorbed
    snap = strobe_cnt;
    press(2, 12);
    chk("t3_glitch_mode", 32'(mode), 32'(exp_mode));
    chk("t3_glitch_strobes", 32'(strobe_cnt - snap), 0);
    snap = strobe_cnt;
    key_adv_n = 1'b0; cyc(12);
    key_adv_n = 1'b1; cyc(2);
    key_adv_n = 1'b0; cyc(1);
    key_adv_n = 1'b1; cyc(12);
    exp_mode = (exp_mode + 1) % 4;
    chk("t3_bounce_mode", 32'(mode), 32'(exp_mode));
    chk("t3_bounce_strobes", 32'(strobe_cnt - snap), 1);

    // 4: clear qualifier, then clear at zero still strobes
    chk("t4_pre_mode", 32'(mode), 2);
    key_clr_n = 1'b0;
    snap = strobe_cnt;
    press(12, 12);
    chk("t4_clr_mode", 32'(mode), 0);
    chk("t4_clr_strobes", 32'(strobe_cnt - snap), 1);
    snap = strobe_cnt;
    press(12, 12);
    chk("t4_clr0_mode", 32'(mode), 0);
    chk("t4_clr0_strobes", 32'(strobe_cnt - snap), 1);
    snap = strobe_cnt;
    cyc(20);
    key_clr_n = 1'b1;
    cyc(5);
    chk("t4_clr_alone_strobes", 32'(strobe_cnt - snap), 0);
    chk("t4_clr_alone_mode", 32'(mode), 0);
    exp_mode = 0;

    // 5: reset mid-debounce with key held through release
    for (int p = 0; p < 3; p++) press(12, 12);
    chk("t5_pre_mode", 32'(mode), 3);
    key_adv_n = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("t5_async_mode", 32'(mode), 0);
    chk("t5_async_blank", 32'(blank), 0);
    cyc(2);
    rst_n = 1'b1;
    snap = strobe_cnt;
    cyc(20);
    chk("t5_held_mode", 32'(mode), 0);
    chk("t5_held_strobes", 32'(strobe_cnt - snap), 0);
    key_adv_n = 1'b1;
    cyc(8);
    chk("t5_release_strobes", 32'(strobe_cnt - snap), 0);
    press(12, 12);
    chk("t5_repress_mode", 32'(mode), 1);
    chk("t5_repress_strobes", 32'(strobe_cnt - snap), 1);
    exp_mode = 1;

    // 6: auto-cycle
    auto_en = 1'b1;
`ifdef MODE_AUTO_CYCLE_EN
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (mode_strobe === 1'b1) begin
        strobe_at.push_back(i);
        chk($sformatf("t6_auto_blank_%0d", i), 32'(blank), 1);
      end
    end
    chk("t6_auto_count", 32'(strobe_at.size()), 3);
    if (strobe_at.size() >= 3) begin
      chk("t6_auto_gap1", 32'(strobe_at[1] - strobe_at[0]), 10);
      chk("t6_auto_gap2", 32'(strobe_at[2] - strobe_at[1]), 10);
    end
    exp_mode = (exp_mode + 3) % 4;
    chk("t6_auto_mode", 32'(mode), 32'(exp_mode));
    auto_en = 1'b0;
    cyc(2);
    snap = strobe_cnt;
    cyc(30);
    chk("t6_auto_off_strobes", 32'(strobe_cnt - snap), 0);
    chk("t6_auto_off_mode", 32'(mode), 32'(exp_mode));
`else
    snap = strobe_cnt;
    for (int i = 0; i < 100; i += 25) begin
      cyc(25);
      chk($sformatf("t6_static_mode_%0d", i), 32'(mode), 32'(exp_mode));
    end
    chk("t6_static_strobes", 32'(strobe_cnt - snap), 0);
    chk("t6_static_queue", 32'(strobe_at.size()), 0);
    auto_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
